// File: rtl/s3g_tx_if.sv
// Bus bundle for the s3g_tx packet transmitter: buffer write port, send request,
// UART byte handshake and status. The pkt_cnt member exists only under S3G_TX_PKT_CNT_EN.
interface s3g_tx_if;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  payload_len;
  logic        send;
  // UART byte handshake: tx_start is a one-cycle request for tx_data. tx_data stays
  // stable until the matching tx_done pulse. A tx_done with no outstanding byte is ignored.
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        packet_sent;
  logic [2:0]  dbg_state;
`ifdef S3G_TX_PKT_CNT_EN
  logic [15:0] pkt_cnt;
`endif

  modport master (
    output wr_en, wr_addr, wr_data, payload_len, send, tx_done,
`ifdef S3G_TX_PKT_CNT_EN
    input  pkt_cnt,
`endif
    input  tx_start, tx_data, busy, packet_sent, dbg_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, payload_len, send, tx_done,
`ifdef S3G_TX_PKT_CNT_EN
    output pkt_cnt,
`endif
    output tx_start, tx_data, busy, packet_sent, dbg_state
  );
endinterface

// File: rtl/s3g_tx.sv
// Packet transmitter: sends 0xD5, length, payload bytes and a CRC-8/MAXIM byte to a UART.
// Define S3G_TX_PKT_CNT_EN to add the 16-bit sent-packet counter (pkt_cnt).
module s3g_tx (
  input  logic   clk,
  input  logic   rst_n,
  s3g_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CRC  = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hD5;

  state_t     state_q, state_d;
  logic       pend_q, pend_d;
  logic       start_q, start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic [7:0] rd_data_q;
  logic [7:0] len_q;
  logic [7:0] crc_q;
  logic       busy_q;
  logic       sent_q;
  logic       accept;
  logic       finish;
  logic       crc_upd;
  logic [7:0] mem [256];

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  // pend_q marks a byte handed to the UART and not yet acknowledged; while it is
  // clear in a send state the next cycle launches that state's byte.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    start_d   = 1'b0;
    tx_data_d = tx_data_q;
    rd_addr_d = rd_addr_q;
    accept    = 1'b0;
    finish    = 1'b0;
    crc_upd   = 1'b0;
    case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        if (bus.send) begin
          accept    = 1'b1;
          state_d   = S_SYNC;
          rd_addr_d = 8'd0;
        end
      end
      S_SYNC, S_LEN, S_DATA, S_CRC: begin
        if (!pend_q) begin
          start_d = 1'b1;
          pend_d  = 1'b1;
          case (state_q)
            S_SYNC:  tx_data_d = SYNC_BYTE;
            S_LEN:   tx_data_d = len_q;
            S_DATA: begin
              tx_data_d = rd_data_q;
              crc_upd   = 1'b1;
            end
            default: tx_data_d = crc_q;
          endcase
        end else if (bus.tx_done) begin
          pend_d = 1'b0;
          case (state_q)
            S_SYNC: state_d = S_LEN;
            S_LEN:  state_d = (len_q == 8'd0) ? S_CRC : S_DATA;
            S_DATA: begin
              if (rd_addr_q == len_q - 8'd1) state_d = S_CRC;
              else rd_addr_d = rd_addr_q + 8'd1;
            end
            default: begin
              state_d = S_IDLE;
              finish  = 1'b1;
            end
          endcase
        end
      end
      default: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= 1'b0;
      tx_data_q <= 8'h00;
      rd_addr_q <= 8'd0;
      len_q     <= 8'd0;
      crc_q     <= 8'h00;
      busy_q    <= 1'b0;
      sent_q    <= 1'b0;
    end else begin
      start_q   <= start_d;
      tx_data_q <= tx_data_d;
      rd_addr_q <= rd_addr_d;
      sent_q    <= finish;
      if (accept) begin
        busy_q <= 1'b1;
        len_q  <= bus.payload_len;
        crc_q  <= 8'h00;
      end else begin
        if (finish) busy_q <= 1'b0;
        if (crc_upd) crc_q <= crc8_step(crc_q, rd_data_q);
      end
    end
  end

  // The read port looks one address ahead so the byte is ready when its slot opens.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_q) mem[bus.wr_addr] <= bus.wr_data;
    rd_data_q <= mem[rd_addr_d];
  end

`ifdef S3G_TX_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pkt_cnt_q <= 16'd0;
    else if (finish) pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign bus.pkt_cnt = pkt_cnt_q;
`endif

  assign bus.tx_start    = start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = busy_q;
  assign bus.packet_sent = sent_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_s3g_tx.sv
// Self-checking bench for s3g_tx: table vectors, hand-written corner sequences and
// random packets checked against a buffer/CRC reference model and a UART responder.
module tb_s3g_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  s3g_tx_if ifc();

  s3g_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  typedef struct {
    string       name;
    int          len;
    logic [71:0] data;
    logic [7:0]  crc;
  } vec_t;

  vec_t       vecs[8];
  int         nvec = 0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         send_cyc = 0;
  int         done_cyc = -10;
  int         timing_err = 0;
  int         timing_base = 0;
  int         proto_err = 0;
  int         spur_req_n = 0;
  int         spur_ack_n = 0;
  int         rx_base = 0;
  int         exp_pkts = 0;
  int         guard;
  int         cnt;
  int         len;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] buf_model[256];

  always @(posedge clk) cyc <= cyc + 1;

  // UART responder: takes each tx_start byte, checks hold/launch timing, answers
  // with tx_done after a random delay. Abandons the byte if reset hits.
  initial begin : uart
    logic [7:0] b;
    int         d;
    int         exp_c;
    bit         aborted;
    ifc.tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (spur_req_n != spur_ack_n) begin
        ifc.tx_done = 1'b1;
        @(posedge clk); #1;
        ifc.tx_done = 1'b0;
        spur_ack_n++;
      end else if (rst_n === 1'b1 && ifc.tx_start === 1'b1) begin
        exp_c = (send_cyc > done_cyc) ? send_cyc + 1 : done_cyc + 1;
        if (cyc != exp_c) timing_err++;
        b = ifc.tx_data;
        rx_q.push_back(b);
        d = $urandom_range(0, 4);
        aborted = 1'b0;
        for (int k = 0; k < d; k++) begin
          @(posedge clk); #1;
          if (rst_n !== 1'b1) aborted = 1'b1;
          else if (!aborted && (ifc.tx_data !== b || ifc.tx_start !== 1'b0)) proto_err++;
        end
        if (!aborted && rst_n === 1'b1) begin
          ifc.tx_done = 1'b1;
          @(posedge clk); #1;
          ifc.tx_done = 1'b0;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    ifc.wr_en   = 1'b1;
    ifc.wr_addr = a;
    ifc.wr_data = d;
    @(posedge clk); #1;
    ifc.wr_en = 1'b0;
    buf_model[a] = d;
  endtask

  // Reference CRC: bit-serial LSB-first LFSR over the modelled payload.
  function automatic logic [7:0] crc_model(input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ buf_model[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 8'h8C;
      end
    end
    return c;
  endfunction

  task automatic build_exp(input int n);
    exp_q.delete();
    exp_q.push_back(8'hD5);
    exp_q.push_back(n[7:0]);
    for (int i = 0; i < n; i++) exp_q.push_back(buf_model[i]);
    exp_q.push_back(crc_model(n));
  endtask

  task automatic start_packet(input int n);
    ifc.payload_len = n[7:0];
    ifc.send = 1'b1;
    @(posedge clk); #1;
    ifc.send = 1'b0;
    send_cyc = cyc;
    check("busy_on_send", ifc.busy, 1);
  endtask

  task automatic wait_sent(input string tag, input int n, input bit noise);
    int g;
    int busy_bad;
    g = 0;
    busy_bad = 0;
    while (ifc.packet_sent !== 1'b1 && g < 40 * (n + 4)) begin
      if (ifc.busy !== 1'b1) busy_bad++;
      if (noise && g >= 2 && g < 14) begin
        ifc.send    = 1'($urandom_range(0, 1));
        ifc.wr_en   = 1'b1;
        ifc.wr_addr = 8'($urandom_range(0, 15));
        ifc.wr_data = 8'($urandom);
      end
      @(posedge clk); #1;
      ifc.send  = 1'b0;
      ifc.wr_en = 1'b0;
      g++;
    end
    check({tag, "_packet_sent"}, ifc.packet_sent, 1);
    check({tag, "_busy_clear"}, ifc.busy, 0);
    check({tag, "_busy_gaps"}, busy_bad, 0);
    @(posedge clk); #1;
    check({tag, "_sent_one_cycle"}, ifc.packet_sent, 0);
  endtask

  task automatic compare_rx(input string tag);
    int n;
    n = rx_q.size() - rx_base;
    check({tag, "_nbytes"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), rx_q[rx_base + i], exp_q[i]);
    rx_base = rx_q.size();
    exp_pkts++;
`ifdef S3G_TX_PKT_CNT_EN
    check({tag, "_pkt_cnt"}, ifc.pkt_cnt, exp_pkts);
`endif
    check({tag, "_byte_timing"}, timing_err - timing_base, 0);
    timing_base = timing_err;
  endtask

  task automatic run_packet(input string tag, input int n);
    build_exp(n);
    start_packet(n);
    wait_sent(tag, n, 1'b0);
    compare_rx(tag);
  endtask

  task automatic add_vec(input string n, input int l, input logic [71:0] d, input logic [7:0] c);
    vecs[nvec].name = n;
    vecs[nvec].len  = l;
    vecs[nvec].data = d;
    vecs[nvec].crc  = c;
    nvec++;
  endtask

  initial begin
    ifc.wr_en = 1'b0;
    ifc.wr_addr = 8'h00;
    ifc.wr_data = 8'h00;
    ifc.payload_len = 8'h00;
    ifc.send = 1'b0;
    rst_n = 1'b0;

    add_vec("one_byte", 1, 72'h01, 8'h5E);
    add_vec("check_str", 9, 72'h393837363534333231, 8'hA1);
    add_vec("empty", 0, 72'h0, 8'h00);
    add_vec("ff_byte", 1, 72'hFF, 8'h35);
    add_vec("two_zero", 2, 72'h0000, 8'h00);

    // Clock/reset: outputs while held in reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", ifc.tx_start, 0);
    check("rst_tx_data", ifc.tx_data, 8'h00);
    check("rst_busy", ifc.busy, 0);
    check("rst_packet_sent", ifc.packet_sent, 0);
`ifdef S3G_TX_PKT_CNT_EN
    check("rst_pkt_cnt", ifc.pkt_cnt, 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table vectors with fixed expected bytes.
    for (int v = 0; v < nvec; v++) begin
      for (int i = 0; i < vecs[v].len; i++) wr(8'(i), vecs[v].data[8*i +: 8]);
      exp_q.delete();
      exp_q.push_back(8'hD5);
      exp_q.push_back(8'(vecs[v].len));
      for (int i = 0; i < vecs[v].len; i++) exp_q.push_back(vecs[v].data[8*i +: 8]);
      exp_q.push_back(vecs[v].crc);
      start_packet(vecs[v].len);
      wait_sent(vecs[v].name, vecs[v].len, 1'b0);
      compare_rx(vecs[v].name);
    end

    // Send on the edge that completes the CRC byte is ignored, one cycle later it is taken.
    wr(8'd0, 8'hA5);
    wr(8'd1, 8'h3C);
    build_exp(2);
    start_packet(2);
    guard = 0;
    while (!(ifc.tx_done === 1'b1 && (rx_q.size() - rx_base) == exp_q.size()) && guard < 200) begin
      @(posedge clk); #2;
      guard++;
    end
    check("b2b_reached_crc_done", guard < 200, 1);
    ifc.send = 1'b1;
    @(posedge clk); #1;
    check("b2b_first_sent", ifc.packet_sent, 1);
    check("b2b_send_ignored", ifc.busy, 0);
    @(posedge clk); #1;
    check("b2b_send_accepted", ifc.busy, 1);
    ifc.send = 1'b0;
    send_cyc = cyc;
    compare_rx("b2b_first");
    wait_sent("b2b_second", 2, 1'b0);
    compare_rx("b2b_second");

    // Send pulses and buffer writes during a packet are ignored.
    for (int i = 0; i < 10; i++) wr(8'(i), 8'($urandom));
    build_exp(10);
    start_packet(10);
    wait_sent("noisy", 10, 1'b1);
    compare_rx("noisy");
    run_packet("after_noise", 10);

    // Random payloads against the model, plus the full 255-byte packet.
    for (int r = 0; r < 5; r++) begin
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) wr(8'(i), 8'($urandom));
      run_packet($sformatf("rand%0d", r), len);
    end
    for (int i = 0; i < 256; i++) wr(8'(i), 8'($urandom));
    run_packet("len255", 255);

    // Reset in the middle of the payload, then recovery with the retained buffer.
    for (int i = 0; i < 20; i++) wr(8'(i), 8'($urandom));
    build_exp(20);
    start_packet(20);
    guard = 0;
    while ((rx_q.size() - rx_base) < 6 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    check("abort_reached_data", guard < 400, 1);
    rst_n = 1'b0;
    #1;
    check("abort_tx_start", ifc.tx_start, 0);
    check("abort_tx_data", ifc.tx_data, 8'h00);
    check("abort_busy", ifc.busy, 0);
    check("abort_packet_sent", ifc.packet_sent, 0);
`ifdef S3G_TX_PKT_CNT_EN
    check("abort_pkt_cnt", ifc.pkt_cnt, 0);
`endif
    exp_pkts = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx_base = rx_q.size();
    timing_base = timing_err;
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_restart", rx_q.size() - rx_base, 0);
    check("abort_idle_busy", ifc.busy, 0);
    run_packet("post_reset", 20);
    run_packet("post_reset2", 5);
    run_packet("post_reset3", 0);
`ifdef S3G_TX_PKT_CNT_EN
    check("three_packets_cnt", ifc.pkt_cnt, 3);
`endif

    // Spurious tx_done while idle has no effect.
    spur_req_n++;
    guard = 0;
    cnt = 0;
    while ((spur_ack_n != spur_req_n || guard < 8) && guard < 40) begin
      @(posedge clk); #1;
      if (ifc.busy !== 1'b0 || ifc.packet_sent !== 1'b0 || ifc.tx_start !== 1'b0) cnt++;
      guard++;
    end
    check("spur_acked", spur_ack_n, spur_req_n);
    check("spur_no_activity", cnt, 0);
`ifdef S3G_TX_PKT_CNT_EN
    check("spur_pkt_cnt", ifc.pkt_cnt, 3);
`endif
    run_packet("after_spur", 3);

    check("tx_data_hold", proto_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
